// File: rtl/md_if.sv
// md_if: issue/result bundle between the E stage and the multiply/divide unit
interface md_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit_param.sv
// md_unit_param: multi-cycle multiply/divide unit with HI/LO registers, flush abort and mthi/mtlo
module md_unit_param #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave bus
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sg, an, bn, bz;
  logic [2*WIDTH-1:0] ea, eb, prod;
  logic [WIDTH-1:0] ma, mb, dv, uq, ur, res_hi, res_lo;
  // Signed ops work on magnitudes and fix signs afterwards; min/-1 wraps back to min with remainder 0.
  always_comb begin
    sg     = ~op_q[0];
    an     = sg & a_q[WIDTH-1];
    bn     = sg & b_q[WIDTH-1];
    bz     = b_q == '0;
    ea     = {{WIDTH{an}}, a_q};
    eb     = {{WIDTH{bn}}, b_q};
    prod   = ea * eb;
    ma     = an ? -a_q : a_q;
    mb     = bn ? -b_q : b_q;
    dv     = bz ? WIDTH'(1) : mb;
    uq     = ma / dv;
    ur     = ma % dv;
    res_lo = op_q[1] ? (bz ? '1 : ((an ^ bn) ? -uq : uq)) : prod[WIDTH-1:0];
    res_hi = op_q[1] ? (bz ? a_q : (an ? -ur : ur)) : prod[2*WIDTH-1:WIDTH];
  end
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start && !bus.flush) begin
          if (bus.op[2] == 1'b0) begin
            state <= bus.op[1] ? DIV : MUL;
            cnt   <= bus.op[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
            op_q  <= bus.op[1:0];
            a_q   <= bus.a;
            b_q   <= bus.b;
          end else if (bus.op == 3'b100) begin
            bus.hi <= bus.a;
          end else if (bus.op == 3'b101) begin
            bus.lo <= bus.a;
          end
        end
      end else if (bus.flush) begin
        state <= IDLE;
      end else if (cnt == '0) begin
        state    <= IDLE;
        bus.done <= 1'b1;
        bus.hi   <= res_hi;
        bus.lo   <= res_lo;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_md_unit_param.sv
// tb_md_unit_param: randomized scoreboard bench for md_unit_param against an arithmetic reference model
module tb_md_unit_param;
  typedef struct {logic [31:0] hi; logic [31:0] lo; int lat;} exp_t;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [31:0] m_hi = 0, m_lo = 0;
  int bcnt = 0;
  md_if #(.WIDTH(32)) bus();
  md_unit_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {hi, lo} straight from the architectural rules, using 64-bit host arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int sq, sr;
    case (o)
      3'd0: return longint'($signed(x)) * longint'($signed(y));
      3'd1: return {32'b0, x} * {32'b0, y};
      3'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      default: return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_n) bcnt = 0;
    else if (bus.done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("retire_hi", bus.hi, e.hi);
        chk("retire_lo", bus.lo, e.lo);
        chk("latency", bcnt, e.lat);
        chk("busy_at_done", {31'b0, bus.busy}, 32'd0);
        m_hi = e.hi;
        m_lo = e.lo;
      end
      bcnt = 0;
    end else if (bus.busy) bcnt++;
    else bcnt = 0;
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic fl);
    logic [63:0] r;
    @(posedge clk) #1;
    bus.start = 1; bus.op = o; bus.a = x; bus.b = y; bus.flush = fl;
    if (!bus.busy && !fl) begin
      if (o[2] == 1'b0) begin
        r = model(o, x, y);
        sb.push_back('{r[63:32], r[31:0], o[1] ? 10 : 5});
      end else if (o == 3'd4) m_hi = x;
      else if (o == 3'd5) m_lo = x;
    end
    @(posedge clk) #1;
    bus.start = 0; bus.flush = 0;
    bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && bus.busy; i++) @(posedge clk) #1;
    if (bus.busy) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy=1 expected busy=0 within 100 cycles");
    end
    @(negedge clk) #1;
  endtask

  task automatic flush_after(input int k);
    repeat (k) @(posedge clk) #1;
    bus.flush = 1;
    @(posedge clk) #1;
    bus.flush = 0;
    void'(sb.pop_back());
    chk("busy_after_flush", {31'b0, bus.busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.flush = 0;
    #12;
    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    chk("reset_done", {31'b0, bus.done}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    #11 rst_n = 1;
    issue(3'd0, 32'h8000_0000, 32'd2, 0);
    wait_idle();
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'h0);
    issue(3'd1, 32'h8000_0000, 32'd2, 0);
    wait_idle();
    chk("multu_hi", bus.hi, 32'h1);
    chk("multu_lo", bus.lo, 32'h0);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    wait_idle();
    chk("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
    issue(3'd3, 32'h1234, 32'd0, 0);
    wait_idle();
    chk("divz_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divz_hi", bus.hi, 32'h1234);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    wait_idle();
    chk("divovf_lo", bus.lo, 32'h8000_0000);
    chk("divovf_hi", bus.hi, 32'h0);
    issue(3'd2, 32'd100, 32'd7, 0);
    flush_after(2);
    repeat (12) @(posedge clk);
    #1;
    chk("flush_hi", bus.hi, m_hi);
    chk("flush_lo", bus.lo, m_lo);
    issue(3'd1, 32'd9, 32'd9, 0);
    issue(3'd5, 32'd5, 32'd0, 0);
    wait_idle();
    chk("mtlo_busy_ignored", bus.lo, 32'd81);
    issue(3'd5, 32'd5, 32'd0, 0);
    chk("mtlo", bus.lo, 32'd5);
    issue(3'd4, 32'hABCD, 32'd0, 1);
    chk("mthi_flush_ignored", bus.hi, m_hi);
    issue(3'd6, 32'h55, 32'h3, 0);
    chk("reserved_busy", {31'b0, bus.busy}, 32'd0);
    issue(3'd0, 32'd3, 32'd4, 0);
    repeat (2) @(posedge clk) #1;
    issue(3'd4, 32'hDEAD, 32'd0, 0);
    wait_idle();
    chk("retire_edge_mthi", bus.hi, 32'd0);
    chk("retire_edge_lo", bus.lo, 32'd12);
    issue(3'd2, 32'd1000, 32'd3, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_busy", {31'b0, bus.busy}, 32'd0);
    chk("async_hi", bus.hi, 32'd0);
    chk("async_lo", bus.lo, 32'd0);
    sb.delete();
    m_hi = 0; m_lo = 0;
    #4 rst_n = 1;
    issue(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    wait_idle();
    chk("post_reset_lo", bus.lo, 32'hFFFF_FFFA);
    for (int i = 0; i < 60; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      issue(o, pick(), pick(), $urandom_range(0, 9) == 0);
      if (o[2] == 1'b0 && sb.size() != 0 && $urandom_range(0, 3) == 0) flush_after($urandom_range(0, o[1] ? 7 : 2));
      wait_idle();
      chk("rand_hi", bus.hi, m_hi);
      chk("rand_lo", bus.lo, m_lo);
    end
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
